// File: rtl/uart_host_tx_if.sv
// Host-side byte write port and serial line of the UART transmit path.
// The master modport is the local writer; the slave modport is uart_host_tx.
interface uart_host_tx_if;
   logic       wr;
   logic [7:0] wdata;
   logic       full;
   logic       empty;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output wr, wdata,
      input  full, empty, tx, tx_busy, tx_done
   );

   modport slave (
      input  wr, wdata,
      output full, empty, tx, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_host_tx.sv
// UART transmit path: byte FIFO, x16 baud divider and 8N1 frame FSM, LSB first.
// Define UART_TX_PARITY_EN to append an even parity bit (8E1, 11-bit frame).
module uart_host_tx #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned DEPTH  = 4
) (
   input logic        clk,
   input logic        rst,
   uart_host_tx_if.slave bus
);

   localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
   localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
   localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW      = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t          state, state_n;
   logic [DW-1:0]   div_cnt;
   logic [3:0]      tick_cnt;
   logic            baud_tick;
   logic            bit_end;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
   logic            par;
`endif

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count, count_n;
   logic            full_q, empty_q;
   logic            push, pop;

   logic            tx_q, tx_n;
   logic            done_q;

   // ---------------- FIFO ----------------
   // full/empty are registered, so a write is judged against the pre-edge state
   assign push = bus.wr && !full_q;

   always_comb begin
      count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count   <= count_n;
         full_q  <= (count_n == (AW+1)'(DEPTH));
         empty_q <= (count_n == '0);
      end
   end

   // ---------------- baud divider ----------------
   // Held at zero in IDLE so each frame starts on a fresh bit boundary.
   assign baud_tick = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
   assign bit_end   = baud_tick && (tick_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
      end else if (state == S_IDLE) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
      end else begin
         div_cnt <= baud_tick ? '0 : div_cnt + 1'b1;
         if (baud_tick) tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // ---------------- frame FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      tx_n    = 1'b1;
      unique case (state)
         S_IDLE: begin
            tx_n = 1'b1;
            if (!empty_q) begin
               pop     = 1'b1;
               state_n = S_START;
            end
         end
         S_START: begin
            tx_n = 1'b0;
            if (bit_end) state_n = S_DATA;
         end
         S_DATA: begin
            tx_n = shift[0];
            if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_n = S_PARITY;
`else
               state_n = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx_n = par;
            if (bit_end) state_n = S_STOP;
         end
`endif
         S_STOP: begin
            tx_n = 1'b1;
            if (bit_end) begin
               // back-to-back frames go straight to START with no idle bit
               if (!empty_q) begin
                  pop     = 1'b1;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         shift   <= '0;
         bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else if (pop) begin
         shift   <= mem[rptr];
         bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= ^mem[rptr];
`endif
      end else if (state == S_DATA && bit_end) begin
         shift   <= {1'b0, shift[7:1]};
         bit_idx <= bit_idx + 1'b1;
      end
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_q   <= 1'b1;
         done_q <= 1'b0;
      end else begin
         tx_q   <= tx_n;
         done_q <= (state == S_STOP) && bit_end;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.tx_done = done_q;
   assign bus.tx_busy = (state != S_IDLE);
   assign bus.full    = full_q;
   assign bus.empty   = empty_q;

endmodule

// File: tb/tb_uart_host_tx.sv
// Self-checking bench for uart_host_tx: directed and random bytes checked
// cycle-by-cycle against frame waveforms computed from the byte value.
module tb_uart_host_tx;

   localparam int unsigned BIT_CLK = 160;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FBITS = 11;
`else
   localparam int unsigned FBITS = 10;
`endif
   localparam int FRAME_CLK = int'(FBITS * BIT_CLK);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_host_tx_if bus();

   uart_host_tx #(
      .CLK_HZ (1_600_000),
      .BAUD   (10_000),
      .DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line level of frame bit idx: start, 8 data LSB first, [even parity], stop
   function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] b);
      bus.wr    = 1'b1;
      bus.wdata = b;
      step();
      bus.wr    = 1'b0;
      bus.wdata = 8'($urandom);
   endtask

   // Current sample is frame clock k0; k<0 are pre-start idle clocks.
   task automatic check_frame(input logic [7:0] b, input int k0, input bit last);
      int bad_tx   = 0;
      int bad_done = 0;
      int bad_busy = 0;
      for (int k = k0; k < FRAME_CLK; k++) begin
         logic et, ed, eb;
         if (k < 0) begin
            et = 1'b1;
            ed = 1'b0;
         end else begin
            et = frame_bit(b, int'(unsigned'(k) / BIT_CLK));
            ed = (k == FRAME_CLK - 1);
            eb = (k == FRAME_CLK - 1) ? !last : 1'b1;
            if (bus.tx_busy !== eb) bad_busy++;
         end
         if (bus.tx !== et)      bad_tx++;
         if (bus.tx_done !== ed) bad_done++;
         step();
      end
      chk($sformatf("frame_%02h_line_err_clks", b), bad_tx, 0);
      chk($sformatf("frame_%02h_done_err_clks", b), bad_done, 0);
      chk($sformatf("frame_%02h_busy_err_clks", b), bad_busy, 0);
   endtask

   task automatic check_quiet(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0 ||
             bus.empty !== 1'b1) bad++;
         step();
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      logic [7:0] q[$];
      int n;

      bus.wr    = 1'b0;
      bus.wdata = 8'h00;

      // reset
      rst = 1'b0;
      repeat (3) step();
      chk("rst_tx", bus.tx, 1);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_busy", bus.tx_busy, 0);
      chk("rst_done", bus.tx_done, 0);
      rst = 1'b1;
      step();
      step();

      // single byte
      do_write(8'hA5);
      chk("single_empty_after_wr", bus.empty, 0);
      check_frame(8'hA5, -2, 1'b1);
      check_quiet("single_idle_after", 20);

      // back-to-back frames
      do_write(8'h00);
      do_write(8'hFF);
      do_write(8'h55);
      check_frame(8'h00, 0, 1'b0);
      check_frame(8'hFF, 0, 1'b0);
      check_frame(8'h55, 0, 1'b1);
      check_quiet("b2b_idle_after", 20);

      // full and dropped writes: 0x10 is popped, 0x11..0x14 fill, 0x15 dropped
      do_write(8'h10);
      do_write(8'h11);
      do_write(8'h12);
      do_write(8'h13);
      chk("full_low_at_3", bus.full, 0);
      do_write(8'h14);
      chk("full_high_at_4", bus.full, 1);
      do_write(8'h15);
      chk("full_held_after_drop", bus.full, 1);
      check_frame(8'h10, 3, 1'b0);
      check_frame(8'h11, 0, 1'b0);
      check_frame(8'h12, 0, 1'b0);
      check_frame(8'h13, 0, 1'b0);
      check_frame(8'h14, 0, 1'b1);
      check_quiet("drop_no_extra_frame", 2 * int'(BIT_CLK));

      // reset mid-frame during data bit 3 of 0x3C
      do_write(8'h3C);
      repeat (702) step();
      chk("midframe_data_bit3", bus.tx, 1);
      rst = 1'b0;
      step();
      chk("midrst_tx", bus.tx, 1);
      chk("midrst_empty", bus.empty, 1);
      chk("midrst_busy", bus.tx_busy, 0);
      chk("midrst_done", bus.tx_done, 0);
      step();
      rst = 1'b1;
      step();
      check_quiet("midrst_quiet", 2000);
      do_write(8'h81);
      check_frame(8'h81, -2, 1'b1);

`ifdef UART_TX_PARITY_EN
      do_write(8'h07);
      check_frame(8'h07, -2, 1'b1);
      do_write(8'h03);
      check_frame(8'h03, -2, 1'b1);
`endif

      // random bursts of 1..3 bytes from idle
      for (int r = 0; r < 3; r++) begin
         q.delete();
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            do_write(q[i]);
         end
         for (int i = 0; i < n; i++) begin
            check_frame(q[i], (i == 0) ? n - 3 : 0, i == n - 1);
         end
         check_quiet($sformatf("rand_%0d_idle_after", r), 10);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
